count_display: RTL
==================

# count_display

Downstream consumer of the 8-bit up/down counter's `c` output. It converts the binary count to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then drives a 3-digit time-multiplexed seven-segment display with leading-zero blanking. It shares `clk` and `clr` with the counter.

## Interface
- `SCAN_DIV`, default 4: clocks each digit stays enabled; legal values are 1 and above.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `c`  in  8: binary count from the counter.
- `bcd`  out  12: last completed conversion. `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units.
- `busy`  out  1: high while a conversion is in progress.
- `an`  out  3: one-hot digit enable. `an[0]` units, `an[1]` tens, `an[2]` hundreds.
- `seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-high.

## Operation
- **Registers:** `state`, `last_bin[7:0]`, `shreg[19:0]`, `bitcnt[2:0]`, `bcd`, `busy`, `pre` (prescaler), `dig[1:0]`.
- **Conversion FSM:** states IDLE, SHIFT, DONE.
  - IDLE, `c != last_bin`: `shreg <= {12'b0, c}`, `last_bin <= c`, `bitcnt <= 0`, `busy <= 1`, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT, one step per clock: add 3 to each of the nibbles `shreg[11:8]`, `[15:12]`, `[19:16]` whose value is 5 or more, then shift the whole register left by 1. After 8 steps (`bitcnt == 7`), go to DONE.
  - DONE: `bcd <= shreg[19:8]`, `busy <= 0`, go to IDLE.
- `c` is ignored outside IDLE. A value changed during a conversion is picked up on the first IDLE edge.
- **Display scan:**
  - `pre` counts 0 to `SCAN_DIV-1`.
  - When `pre` wraps, `dig` advances 0, 1, 2, 0.
  - `an` = one-hot of `dig`, combinational.
- **Segment codes (hex):** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other nibble gives 00.
- **Blanking (`seg` = 00):**
  - Hundreds digit blanks when the hundreds value is 0.
  - Tens digit blanks when hundreds and tens are both 0.
  - Units digit is never blanked.
- `seg` is combinational from `dig` and `bcd`.

## Timing
- **Reset values:** `state` IDLE, `last_bin` 0, `bcd` 000, `busy` 0, `pre` 0, `dig` 0.
  - So after reset `an` = 001 and `seg` = 3F.
  - `c` = 0 after reset starts no conversion.
- **Latency:** with a changed `c` stable at edge 1:
  - `busy` is high after edge 1.
  - Shift steps occur on edges 2–9.
  - `bcd` updates and `busy` falls on edge 10.
  - Total: 10 clocks from change to display.
- **Back-to-back:** the earliest next start is edge 11. At most one conversion per 10 clocks.
- **Display lag:** if the count changes faster than every 10 clocks, the display shows the latest completed value. Intermediate values are skipped; the display never shows a partial result.
- **`clr` mid-conversion:** abort on that edge and apply all reset values. After `clr` falls, a nonzero `c` starts a conversion on the first edge.
- **`clr` and a `c` change on the same edge:** `clr` wins.
- **`SCAN_DIV` = 1:** the digit advances every clock.

## Structure
- **Package `count_display_pkg`:**
  - state enum typedef (IDLE, SHIFT, DONE);
  - the ten segment-code constants plus a BLANK constant (00);
  - a digit-to-segment decode function.
- **Sub-module `bin2bcd_seq`:** the FSM, shift register and `busy`/`bcd` outputs.
- **Top level:** prescaler, scan and blanking logic.

## Test plan
1. **Reset:** hold `clr` for 2 cycles with `c` = 0 → `bcd` = 000, `busy` = 0, `an` = 001, `seg` = 3F, and no conversion starts.
2. **`c` = 0xF0 (240):**
   - `busy` high from edge 1 to edge 9;
   - `bcd` = 12'h240 at edge 10;
   - scan shows units 3F, tens 66, hundreds 5B.
3. **`c` = 255 → `bcd` = 255. Then `c` = 7:**
   - `bcd` = 007;
   - hundreds and tens `seg` = 00, units `seg` = 07.
4. **`c` = 100, then 101 at edge 4:**
   - `bcd` = 100 at edge 10;
   - a new conversion starts at edge 11;
   - `bcd` = 101 at edge 20.
5. **`clr` pulsed at edge 5 of a conversion of 200:**
   - `busy` = 0 and `bcd` = 000 immediately;
   - with `c` still 200 after release, `bcd` = 200 ten clocks later.
6. **`SCAN_DIV` = 4, `c` = 10:**
   - `an` = 001, 010, 100, 4 clocks each, repeating;
   - `seg` = 3F, 06, 00 respectively.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count_display block.
// Contents: conversion FSM state enum, seven-segment codes ({g,f,e,d,c,b,a},
// active-high), and a BCD digit to segment decode function.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles decode to all segments off.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   c    - 8-bit binary input, sampled only while idle
//   bcd  - last completed conversion {hundreds, tens, units}
//   busy - high while a conversion is in progress
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  c,
  output logic [11:0] bcd,
  output logic        busy
);

  state_t      state;
  logic [7:0]  last_bin;
  logic [19:0] shreg;
  logic [2:0]  bitcnt;
  logic [19:0] adjd;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // BCD nibbles corrected before each left shift.
  always_comb begin
    adjd = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      last_bin <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      bcd      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c != last_bin) begin
            shreg    <= {12'b0, c};
            last_bin <= c;
            bitcnt   <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg  <= {adjd[18:0], 1'b0};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd   <= shreg[19:8];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// Converts the counter value to BCD and drives a 3-digit multiplexed
// seven-segment display with leading-zero blanking.
// Parameters:
//   SCAN_DIV - clocks each digit stays enabled (>= 1)
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   c    - 8-bit binary count
//   bcd  - last completed conversion {hundreds, tens, units}
//   busy - conversion in progress
//   an   - one-hot digit enable (an[0] units .. an[2] hundreds)
//   seg  - segments {g,f,e,d,c,b,a}, active-high
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  c,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  // Keep at least one prescaler bit so SCAN_DIV = 1 elaborates cleanly.
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic [1:0]       dig;
  logic [3:0]       hund, tens, units;

  bin2bcd_seq u_conv (
    .clk  (clk),
    .clr  (clr),
    .c    (c),
    .bcd  (bcd),
    .busy (busy)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      pre <= '0;
      dig <= '0;
    end else if (32'(pre) == SCAN_DIV - 1) begin
      pre <= '0;
      dig <= (dig == 2'd2) ? 2'd0 : dig + 2'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  assign hund  = bcd[11:8];
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

  always_comb begin
    an  = '0;
    seg = SEG_BLANK;
    case (dig)
      2'd0: begin
        an  = 3'b001;
        seg = seg_decode(units);
      end
      2'd1: begin
        an  = 3'b010;
        seg = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
      end
      2'd2: begin
        an  = 3'b100;
        seg = (hund == 4'd0) ? SEG_BLANK : seg_decode(hund);
      end
      default: begin
        an  = '0;
        seg = SEG_BLANK;
      end
    endcase
  end

endmodule
